// File: rtl/exe_pkg.sv
// exe_pkg: opcodes, FSM states and default latencies shared by the execution sequencer.
package exe_pkg;
  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_SCALE = 3'd2;
  localparam logic [2:0] OP_MULT  = 3'd3;
  localparam logic [2:0] OP_TRANS = 3'd4;
  localparam logic [2:0] OP_WMEM  = 3'd6;
  localparam logic [2:0] OP_STOP  = 3'd7;
  localparam int DEF_OP_W      = 3;
  localparam int DEF_CNT_W     = 4;
  localparam int DEF_LAT_ADD   = 1;
  localparam int DEF_LAT_SCALE = 2;
  localparam int DEF_LAT_MULT  = 4;
  localparam int DEF_LAT_TRANS = 1;
  typedef enum logic [1:0] {IDLE, EXEC, WB, HALT} state_t;
  function automatic int lat_m1(input int lat);
    return lat < 1 ? 0 : lat - 1;
  endfunction
endpackage

// File: rtl/exe_lat_counter.sv
// exe_lat_counter: loadable down-counter that holds at zero and flags it.
module exe_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/exe_sequencer.sv
// exe_sequencer: accepts one instruction, pulses one-hot unit enables for a per-op latency, then a writeback strobe.
// Optional EXE_SEQ_PERF_CNT_EN adds retire_cnt and stall_cnt performance counters.
module exe_sequencer import exe_pkg::*; #(
  parameter int OP_W      = DEF_OP_W,
  parameter int LAT_ADD   = DEF_LAT_ADD,
  parameter int LAT_SCALE = DEF_LAT_SCALE,
  parameter int LAT_MULT  = DEF_LAT_MULT,
  parameter int LAT_TRANS = DEF_LAT_TRANS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            instr_valid,
  input  logic [OP_W+1:0] instr,
  output logic            instr_ready,
  output logic            read_from,
  output logic            add_en,
  output logic            scale_en,
  output logic            mult_en,
  output logic            transpose_en,
  output logic            add_or_sub,
  output logic            write_to_reg,
  output logic            write_to_mem,
  output logic            retire,
  output logic            busy,
  output logic            halted,
  output logic            illegal
`ifdef EXE_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]     retire_cnt,
  output logic [31:0]     stall_cnt
`endif
);
  localparam logic [CNT_W-1:0] LA = CNT_W'(lat_m1(LAT_ADD));
  localparam logic [CNT_W-1:0] LS = CNT_W'(lat_m1(LAT_SCALE));
  localparam logic [CNT_W-1:0] LM = CNT_W'(lat_m1(LAT_MULT));
  localparam logic [CNT_W-1:0] LT = CNT_W'(lat_m1(LAT_TRANS));
  state_t state, ns;
  logic [OP_W-1:0] op_in;
  logic [2:0] code, op_q, op_n;
  logic rf_q, rf_n, wr_q, wr_n, accept, bad, zero, exec_n, wb_n;
  logic [CNT_W-1:0] load_val;
  assign op_in = instr[OP_W+1:2];
  assign code = op_in[2:0];
  always_comb begin
    accept = instr_valid & instr_ready;
    bad = int'(op_in) > 7 || code == 3'd5;
    ns = state;
    if (state == IDLE && accept && !bad) ns = code == OP_STOP ? HALT : code == OP_WMEM ? WB : EXEC;
    else if (state == EXEC && zero) ns = WB;
    else if (state == WB) ns = IDLE;
    op_n = accept ? code : op_q;
    rf_n = accept ? instr[1] : rf_q;
    wr_n = accept ? instr[0] : wr_q;
    exec_n = ns == EXEC;
    wb_n = ns == WB;
    load_val = code == OP_SCALE ? LS : code == OP_MULT ? LM : code == OP_TRANS ? LT : LA;
  end
  exe_lat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .reset_n(reset_n), .load(accept), .dec(state == EXEC), .load_val(load_val), .zero(zero)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= ns;
  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      op_q <= '0;
      rf_q <= 1'b0;
      wr_q <= 1'b0;
      instr_ready <= 1'b1;
      busy <= 1'b0;
      halted <= 1'b0;
      read_from <= 1'b0;
      add_en <= 1'b0;
      add_or_sub <= 1'b0;
      scale_en <= 1'b0;
      mult_en <= 1'b0;
      transpose_en <= 1'b0;
      retire <= 1'b0;
      write_to_reg <= 1'b0;
      write_to_mem <= 1'b0;
      illegal <= 1'b0;
    end else begin
      op_q <= op_n;
      rf_q <= rf_n;
      wr_q <= wr_n;
      instr_ready <= ns == IDLE;
      busy <= exec_n | wb_n;
      halted <= ns == HALT;
      read_from <= (exec_n | wb_n) & rf_n;
      add_en <= exec_n & (op_n == OP_ADD | op_n == OP_SUB);
      add_or_sub <= exec_n & op_n == OP_SUB;
      scale_en <= exec_n & op_n == OP_SCALE;
      mult_en <= exec_n & op_n == OP_MULT;
      transpose_en <= exec_n & op_n == OP_TRANS;
      retire <= wb_n;
      write_to_reg <= wb_n & wr_n;
      write_to_mem <= wb_n & op_n == OP_WMEM;
      illegal <= illegal | (accept & bad);
    end
`ifdef EXE_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      retire_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      retire_cnt <= retire_cnt + 32'(retire);
      stall_cnt <= stall_cnt + 32'(instr_valid & ~instr_ready & (state != HALT));
    end
`endif
endmodule

// File: tb/tb_exe_sequencer.sv
// tb_exe_sequencer: directed literal checks plus randomized traffic against a cycle-offset model.
module tb_exe_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic instr_valid = 1'b0;
  logic [4:0] instr = '0;
  logic instr_ready, read_from, add_en, scale_en, mult_en, transpose_en, add_or_sub;
  logic write_to_reg, write_to_mem, retire, busy, halted, illegal;
`ifdef EXE_SEQ_PERF_CNT_EN
  logic [31:0] retire_cnt, stall_cnt;
`endif
  int total = 0, nbad = 0;
  logic chk_on = 1'b0;
  int cyc = 0, acc_cyc = 0, lat_q = 0;
  logic active = 1'b0, mhalt = 1'b0, mill = 1'b0, mrf = 1'b0, mwr = 1'b0;
  logic [2:0] mop = '0, o;

  exe_sequencer dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .read_from(read_from), .add_en(add_en), .scale_en(scale_en),
    .mult_en(mult_en), .transpose_en(transpose_en), .add_or_sub(add_or_sub),
    .write_to_reg(write_to_reg), .write_to_mem(write_to_mem), .retire(retire),
    .busy(busy), .halted(halted), .illegal(illegal)
`ifdef EXE_SEQ_PERF_CNT_EN
    , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [2:0] op);
    case (op)
      3'd2: return 2;
      3'd3: return 4;
      3'd6: return 0;
      default: return 1;
    endcase
  endfunction

  // Expectations are a function of cycles elapsed since the last accept.
  function automatic logic m_ex();
    return active && (cyc - acc_cyc) >= 1 && (cyc - acc_cyc) <= lat_q;
  endfunction
  function automatic logic m_wb();
    return active && (cyc - acc_cyc) == lat_q + 1;
  endfunction
  function automatic logic m_ready();
    return !mhalt && !m_ex() && !m_wb();
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active = 1'b0;
      mhalt = 1'b0;
      mill = 1'b0;
    end else begin
      if (instr_valid && m_ready()) begin
        o = instr[4:2];
        if (o == 3'd5) mill = 1'b1;
        else if (o == 3'd7) mhalt = 1'b1;
        else begin
          active = 1'b1;
          acc_cyc = cyc;
          mop = o;
          mrf = instr[1];
          mwr = instr[0];
          lat_q = lat_of(o);
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("ready", 32'(instr_ready), 32'(m_ready()));
    chk("busy", 32'(busy), 32'(m_ex() || m_wb()));
    chk("halted", 32'(halted), 32'(mhalt));
    chk("illegal", 32'(illegal), 32'(mill));
    chk("read_from", 32'(read_from), 32'((m_ex() || m_wb()) && mrf));
    chk("add_en", 32'(add_en), 32'(m_ex() && (mop == 3'd0 || mop == 3'd1)));
    chk("add_or_sub", 32'(add_or_sub), 32'(m_ex() && mop == 3'd1));
    chk("scale_en", 32'(scale_en), 32'(m_ex() && mop == 3'd2));
    chk("mult_en", 32'(mult_en), 32'(m_ex() && mop == 3'd3));
    chk("transpose_en", 32'(transpose_en), 32'(m_ex() && mop == 3'd4));
    chk("retire", 32'(retire), 32'(m_wb()));
    chk("write_to_reg", 32'(write_to_reg), 32'(m_wb() && mwr));
    chk("write_to_mem", 32'(write_to_mem), 32'(m_wb() && mop == 3'd6));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] ins);
    int n = 0;
    instr = ins;
    instr_valid = 1'b1;
    while (!instr_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("issue_timeout", 32'(n), 32'd0);
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [2:0] op;
    #1 reset_n = 1'b0;
    step();
    chk_on = 1'b1;
    step();
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    reset_n = 1'b1;
    step();
    issue(5'b000_0_1);
    chk("add_en_on", 32'(add_en), 32'd1);
    step();
    chk("add_en_off", 32'(add_en), 32'd0);
    chk("add_retire", 32'(retire), 32'd1);
    chk("add_wreg", 32'(write_to_reg), 32'd1);
    chk("add_aos", 32'(add_or_sub), 32'd0);
    step();
    issue(5'b011_1_0);
    for (int i = 1; i <= 4; i++) begin
      chk("mult_en", 32'(mult_en), 32'd1);
      chk("mult_rf", 32'(read_from), 32'd1);
      chk("mult_rdy", 32'(instr_ready), 32'd0);
      step();
    end
    chk("mult_retire", 32'(retire), 32'd1);
    chk("mult_rf_wb", 32'(read_from), 32'd1);
    chk("mult_rdy_wb", 32'(instr_ready), 32'd0);
    step();
    instr = 5'b001_0_1;
    instr_valid = 1'b1;
    step();
    chk("sub_aos", 32'(add_or_sub), 32'd1);
    chk("sub_en", 32'(add_en), 32'd1);
    instr = 5'b110_0_1;
    step();
    chk("sub_retire", 32'(retire), 32'd1);
    chk("sub_aos_wb", 32'(add_or_sub), 32'd0);
    step();
    chk("wm_rdy", 32'(instr_ready), 32'd1);
    chk("wm_early", 32'(write_to_mem), 32'd0);
    step();
    instr_valid = 1'b0;
    chk("wm_strobe", 32'(write_to_mem), 32'd1);
    chk("wm_retire", 32'(retire), 32'd1);
    chk("wm_wreg", 32'(write_to_reg), 32'd1);
    step();
    issue(5'b101_0_0);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_rdy", 32'(instr_ready), 32'd1);
    chk("ill_retire", 32'(retire), 32'd0);
    issue(5'b010_0_0);
    chk("scale_en1", 32'(scale_en), 32'd1);
    step();
    chk("scale_en2", 32'(scale_en), 32'd1);
    step();
    chk("scale_off", 32'(scale_en), 32'd0);
    chk("scale_retire", 32'(retire), 32'd1);
    chk("ill_sticky", 32'(illegal), 32'd1);
    step();
    issue(5'b111_0_0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_rdy", 32'(instr_ready), 32'd0);
    instr = 5'b000_0_1;
    instr_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      cnt += int'(add_en) + int'(retire);
    end
    chk("halt_ignore", 32'(cnt), 32'd0);
    instr_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("halt_clr", 32'(halted), 32'd0);
    chk("ill_clr", 32'(illegal), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    issue(5'b011_0_1);
    step();
    step();
    chk("abort_pre", 32'(mult_en), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_en", 32'(mult_en), 32'd0);
    chk("abort_retire", 32'(retire), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
`ifdef EXE_SEQ_PERF_CNT_EN
    chk("abort_rcnt", retire_cnt, 32'd0);
`endif
    step();
    reset_n = 1'b1;
    step();
    chk("abort_no_retire", 32'(retire), 32'd0);
    for (int i = 0; i < 600; i++) begin
      if (instr_ready) begin
        op = 3'($urandom_range(0, 7));
        if (op == 3'd7 && $urandom % 4 != 0) op = 3'd0;
        instr = {op, 1'($urandom), 1'($urandom)};
      end
      instr_valid = ($urandom % 3) != 0;
      if ((mhalt && $urandom % 4 == 0) || $urandom % 80 == 0) begin
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
      end else step();
    end
    instr_valid = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end
endmodule

// File: doc/exe_sequencer.md
Name: exe_sequencer

Overview:
- Parametrised successor to the single-cycle opcode decoder in the matrix CPU execution path.
- Accepts one instruction per valid/ready handshake and drives one-hot unit enables for a per-op configurable number of cycles.
- Issues a single-cycle writeback strobe, then accepts the next instruction; also provides halt and illegal-opcode status.
- Sits between instruction fetch and the add/sub, scale, multiply and transpose units plus register/memory write control.

Parameters:
- OP_W, 3, opcode field width; instr width is OP_W+2.
- LAT_ADD, 1, enable cycles for add/sub.
- LAT_SCALE, 2, enable cycles for scale.
- LAT_MULT, 4, enable cycles for multiply.
- LAT_TRANS, 1, enable cycles for transpose.
- CNT_W, 4, latency counter width; every LAT_* must be at most 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instr is valid this cycle.
- instr  in  OP_W+2  fields: [OP_W+1:2] opcode, [1] read_from (0=reg, 1=mem), [0] write_to_reg request.
- instr_ready  out  1  sequencer can accept an instruction.
- read_from  out  1  latched instr[1], held from the cycle after accept through WB.
- add_en, scale_en, mult_en, transpose_en  out  1 each  unit enables, one-hot or all zero.
- add_or_sub  out  1  1 only during a sub EXEC, else 0.
- write_to_reg  out  1  one-cycle strobe in WB when latched instr[0]=1.
- write_to_mem  out  1  one-cycle strobe in WB for the write_mem opcode.
- retire  out  1  one-cycle pulse in WB.
- busy  out  1  state is EXEC or WB.
- halted  out  1  state is HALT.
- illegal  out  1  sticky illegal-opcode flag.

Behaviour:
- Opcodes (low 3 bits): 0 add, 1 sub, 2 scale, 3 mult, 4 transpose, 5 unused, 6 write_mem, 7 stop.
- Opcodes at or above 8, when OP_W>3, are illegal.
- All outputs are registered.
- Reset (async assert, sync deassert assumed upstream): state IDLE; every output 0 except instr_ready=1; illegal cleared.
- Reset mid-operation aborts the operation with no retire.
- States: IDLE, EXEC, WB, HALT.
- IDLE: instr_ready=1. Accept on the clk edge where instr_valid & instr_ready. On accept, latch instr and go to:
  - opcodes 0-4: EXEC, counter loaded with LAT-1; a LAT of 0 is treated as 1.
  - write_mem: WB directly.
  - stop: HALT.
  - unused or illegal: set illegal=1, stay IDLE, no retire, no enables.
- EXEC: instr_ready=0. The matching enable is held high for exactly LAT cycles; counter decrements each cycle. On counter==0, go to WB.
- WB: one cycle. retire=1; write_to_reg=latched[0]; write_to_mem=1 if write_mem; enables 0. Next state IDLE.
- Write_to_reg applies to every retired op, including write_mem.
- Latency: accept edge to retire high = LAT+1 cycles for compute ops, 1 cycle for write_mem. Back-to-back throughput is one instruction per LAT+2 cycles.
- HALT: instr_ready=0, halted=1, all enables 0. Only reset_n exits HALT.
- instr_valid while instr_ready=0 is ignored; the upstream holds instr stable.
- No tri-state or x values are ever driven; unused outputs are 0.

Optional Feature:
- Macro EXE_SEQ_PERF_CNT_EN.
- Defined: adds output retire_cnt (32 bits), incremented on every retire pulse, wrapping at 2^32-1 to 0, and cleared by reset; adds output stall_cnt (32 bits), incremented each cycle instr_valid=1 & instr_ready=0 outside HALT.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Shared package exe_pkg:
  - opcode localparams OP_ADD through OP_STOP;
  - state enum {IDLE, EXEC, WB, HALT};
  - default latency constants.
- One natural sub-module: exe_lat_counter (loadable down-counter, CNT_W wide, with zero flag), instantiated once.

Test Plan:
- Reset, then add with instr=5'b000_0_1 and valid for 1 cycle -> add_en high exactly 1 cycle; next cycle retire=1, write_to_reg=1, add_or_sub=0.
- mult with read_from=1 and LAT_MULT=4 -> mult_en high 4 cycles, read_from=1 throughout, retire at accept+5, instr_ready low over those 5 cycles.
- sub, then write_mem back-to-back with valid held -> add_or_sub=1 during sub EXEC; write_mem accepted the cycle after sub WB; write_to_mem pulses 1 cycle later.
- Opcode 5 -> illegal=1 sticky, no retire, instr_ready stays 1; a following scale still executes with scale_en for 2 cycles.
- stop -> halted=1, instr_ready=0; later valid add ignored for 10 cycles; reset_n low clears halted and illegal.
- reset_n low during the 3rd mult EXEC cycle -> mult_en drops asynchronously, no retire; with EXE_SEQ_PERF_CNT_EN, retire_cnt=0 after reset.
